// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes six snapshotted BCD digits onto a common-anode display with blanking, blink and colon.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic       lz_blank,
  input  logic [2:0] blink_sel,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [FW-1:0] fcnt;
  logic phase;
  logic [3:0] shadow [6];
  logic [3:0] dig;
  logic [6:0] dec;
  logic slot_end, frame_end, fr_last, blank;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == 3'd5;
  assign fr_last = fcnt == FW'(BLINK_FRAMES - 1);
  // Digit pairs share a blink bit: idx 0-1 seconds, 2-3 minutes, 4-5 hours.
  assign blank = (idx == 3'd5 && lz_blank && shadow[5] == 4'd0) || (phase && blink_sel[idx[2:1]]);
  always_comb begin
    dig = shadow[idx];
    dec = 7'h3F;
    case (dig)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
      fcnt <= '0;
      phase <= 1'b0;
      shadow <= '{default: 4'd0};
      an_n <= 6'h3F;
      seg_n <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      if (frame_end) fcnt <= fr_last ? '0 : fcnt + 1'b1;
      if (frame_end && fr_last) phase <= ~phase;
      if (cnt == '0 && idx == 3'd0) shadow <= '{s1, s2, m1, m2, h1, h2};
      an_n <= cnt >= CW'(BLANK_CYC) ? ~(6'd1 << idx) : 6'h3F;
      seg_n <= blank ? 7'h7F : dec;
      dp_n <= !((idx == 3'd2 || idx == 3'd4) && !phase);
    end
  end
endmodule
